// File: rtl/add_serial_pkg.sv
// Shared types and default sizing for the serial-adder arbiter slice.
package add_serial_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam int NREQ_DEF    = 4;
  localparam int W_DEF       = 8;
  localparam int ADD_LAT_DEF = 9;

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: lowest-index requester at or above ptr, with wrap.
// Purely combinational; no backpressure of its own.
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  always_comb begin
    logic found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found   = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/add_serial_arb.sv
// Arbitrates NREQ requesters onto one shared serial adder; grant-to-grant 12 cycles at defaults.
// req_ready only in IDLE; result held in RESP until rsp_ready.
module add_serial_arb
  import add_serial_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int W       = W_DEF,
  parameter int ADD_LAT = ADD_LAT_DEF,
  parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_sum,
  input  logic            rsp_ready,
  output logic            add_en,
  output logic [W-1:0]    add_a,
  output logic [W-1:0]    add_b,
  input  logic [W-1:0]    add_out,
  output logic            busy
);

  localparam int CW = (ADD_LAT > 2) ? $clog2(ADD_LAT - 1) : 1;

  state_t          state;
  logic [IDW-1:0]  ptr;
  logic [CW-1:0]   wait_cnt;
  logic [W-1:0]    lat_a;
  logic [W-1:0]    lat_b;
  logic [IDW-1:0]  lat_id;
  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gnt_idx;
  logic [IDW-1:0]  ptr_nxt;

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign ptr_nxt   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + IDW'(1);
  assign req_ready = (state == IDLE && !rst) ? gnt : '0;
  assign add_a     = lat_a;
  assign add_b     = lat_b;
  assign rsp_id    = lat_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      wait_cnt  <= '0;
      lat_a     <= '0;
      lat_b     <= '0;
      lat_id    <= '0;
      rsp_sum   <= '0;
      rsp_valid <= 1'b0;
      add_en    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            lat_a  <= req_a[int'(gnt_idx)*W +: W];
            lat_b  <= req_b[int'(gnt_idx)*W +: W];
            lat_id <= gnt_idx;
            ptr    <= ptr_nxt;
            add_en <= 1'b1;
            busy   <= 1'b1;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          add_en   <= 1'b0;
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (wait_cnt == CW'(ADD_LAT - 2)) begin
            add_en <= 1'b1;
            state  <= CAPTURE;
          end
        end
        CAPTURE: begin
          // The second add_en pulse hands the adder back to idle.
          rsp_sum   <= add_out;
          add_en    <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          add_en    <= 1'b0;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/add_serial_arb.md
ADD_SERIAL_ARB -- requirements
Module: add_serial_arb

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters.
REQ-002 The block SHALL have parameter W, default 8: operand and sum width.
REQ-003 The block SHALL have parameter ADD_LAT, default 9: cycles from the add_en issue cycle to the cycle in which add_out holds the final sum.
REQ-004 The block SHALL have port clk, input, 1: clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 The block SHALL have port req_valid, input, NREQ: per-requester operation request.
REQ-007 The block SHALL have port req_a, input, NREQ*W: operand A per requester; requester i uses bits [i*W +: W].
REQ-008 The block SHALL have port req_b, input, NREQ*W: operand B per requester, packed like req_a.
REQ-009 The block SHALL have port req_ready, output, NREQ: one-hot grant/accept strobe.
REQ-010 The block SHALL have port rsp_valid, output, 1: result available.
REQ-011 The block SHALL have port rsp_id, output, clog2(NREQ): index of the requester owning the result.
REQ-012 The block SHALL have port rsp_sum, output, W: result, (A+B) mod 2^W.
REQ-013 The block SHALL have port rsp_ready, input, 1: result consumer accept.
REQ-014 The block SHALL have port add_en, output, 1: start/release strobe to the shared serial adder.
REQ-015 The block SHALL have ports add_a and add_b, output, W each: operands driven to the adder.
REQ-016 The block SHALL have port add_out, input, W: adder result.
REQ-017 The block SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, CAPTURE and RESP.
REQ-019 IDLE: if any req_valid is high, the block SHALL assert req_ready for the round-robin winner only (combinational, this cycle), latch its a, b and id, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 Round-robin SHALL search from pointer ptr upward with wrap; after a grant to i, ptr SHALL become (i+1) mod NREQ; ptr reset value is 0.
REQ-021 ISSUE: add_en SHALL be 1 and add_a/add_b SHALL equal the latched operands; the next state SHALL be WAIT with wait_cnt=0.
REQ-022 WAIT: add_en SHALL be 0 and wait_cnt SHALL increment each cycle; on wait_cnt==ADD_LAT-2 the next state SHALL be CAPTURE (8 WAIT cycles at default).
REQ-023 CAPTURE: add_out SHALL be registered into rsp_sum, add_en SHALL be 1 for this single cycle (releases the adder to idle), and the next state SHALL be RESP.
REQ-024 RESP: rsp_valid SHALL be 1, rsp_id = latched id; on rsp_ready the next state SHALL be IDLE; otherwise the block SHALL hold RESP with rsp_sum/rsp_id stable.
REQ-025 add_a/add_b SHALL hold the latched operands in all states; add_en SHALL be 0 outside ISSUE and CAPTURE.
REQ-026 Minimum spacing SHALL be 12 cycles from grant to next grant, with rsp_ready held high.
REQ-027 req_valid/req_a/req_b SHALL be sampled only in IDLE; changes in other states SHALL have no effect; a request SHALL remain pending until granted.
REQ-028 Carry-out SHALL be discarded: 0xFF+0x01 yields rsp_sum=0x00.
REQ-029 req_ready SHALL be 0 in all states except IDLE, and at most one bit SHALL be set.

Reset
REQ-030 On rst: state=IDLE, ptr=0, wait_cnt=0, latched operands=0, rsp_sum=0, rsp_id=0; all outputs SHALL be 0.
REQ-031 rst mid-operation SHALL abort without a response; the adder SHALL share the same rst so both return to idle together.

Structure
REQ-032 Package add_serial_pkg SHALL hold the state enum and the defaults for NREQ, W and ADD_LAT.
REQ-033 Round-robin selection SHALL be a sub-module rr_arb (req vector and ptr in; one-hot grant and index out).

Verification
REQ-034 Single req0 with a=0x5A, b=0x3C, rsp_ready=1: req_ready[0] in cycle 0, add_en in cycles 1 and 10, rsp_valid in cycle 11 with rsp_sum=0x96 and rsp_id=0.
REQ-035 req_valid=4'b1111 held: grants SHALL occur in order 0,1,2,3,0, spaced 12 cycles apart.
REQ-036 Wrap case: req3 with 0xFF+0x01 SHALL yield rsp_sum=0x00.
REQ-037 rsp_ready low for 5 cycles in RESP: rsp_valid/rsp_sum SHALL stay stable and no req_ready SHALL assert; a new grant SHALL follow 1 cycle after accept.
REQ-038 rst pulsed in WAIT: busy SHALL fall to 0 immediately with no rsp_valid; a fresh request afterwards SHALL complete with the correct sum.
REQ-039 req1 deasserted during WAIT while req2 remains pending: the next grant SHALL go to req2.
